// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - time-multiplexed common-anode 7-segment scan driver
//
// Purpose:
//   Scans NUM_DIGITS common-anode digits one slot at a time. Supports decimal
//   points, leading-zero blanking and PWM brightness. New values are loaded
//   into a shadow register and moved to the displayed (active) register only
//   at a frame boundary, so a frame never shows a mix of old and new digits.
//
// Ports:
//   clk          system clock, all logic on posedge
//   clr          synchronous active-high reset
//   digits_in    hex nibbles, MS nibble = leftmost digit
//   dp_in        decimal points (1 = lit), MSB = leftmost digit
//   load         1-cycle strobe, captures digits_in/dp_in into the shadow
//   pending      1 while the shadow holds data not yet displayed
//   blank_lz     1 = blank leading zeros
//   brightness   on-time per slot = (brightness+1)/2**DUTY_W
//   AN           anode enables, active-low, AN[NUM_DIGITS-1] = leftmost
//   CA           segments {a,b,c,d,e,f,g}, active-low
//   DP           decimal point, active-low
//   frame_start  1-cycle pulse on the first cycle of the leftmost-digit slot

module seven_seg_scan_ctrl #(
  parameter int NUM_DIGITS    = 4,
  parameter int PRESCALE_LOG2 = 18,
  parameter int DUTY_W        = 4
) (
  input  logic                      clk,
  input  logic                      clr,
  input  logic [4*NUM_DIGITS-1:0]   digits_in,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic                      load,
  output logic                      pending,
  input  logic                      blank_lz,
  input  logic [DUTY_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]     AN,
  output logic [6:0]                CA,
  output logic                      DP,
  output logic                      frame_start
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  logic [PRESCALE_LOG2-1:0] slot_cnt;
  logic [IDX_W-1:0]         idx;
  logic [4*NUM_DIGITS-1:0]  shadow_digits;
  logic [NUM_DIGITS-1:0]    shadow_dp;
  logic [4*NUM_DIGITS-1:0]  active_digits;
  logic [NUM_DIGITS-1:0]    active_dp;

  logic                     slot_end;
  logic                     commit;
  logic [IDX_W-1:0]         sel;
  logic [3:0]               cur_nib;
  logic                     cur_dp;
  logic [NUM_DIGITS-1:0]    blank_vec;
  logic                     zero_run;
  logic [DUTY_W-1:0]        duty_slot;
  logic                     lit;
  logic [NUM_DIGITS-1:0]    an_next;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'h0: seg_decode = 7'b0000001;
      4'h1: seg_decode = 7'b1001111;
      4'h2: seg_decode = 7'b0010010;
      4'h3: seg_decode = 7'b0000110;
      4'h4: seg_decode = 7'b1001100;
      4'h5: seg_decode = 7'b0100100;
      4'h6: seg_decode = 7'b0100000;
      4'h7: seg_decode = 7'b0001111;
      4'h8: seg_decode = 7'b0000000;
      4'h9: seg_decode = 7'b0000100;
      4'hA: seg_decode = 7'b0001000;
      4'hB: seg_decode = 7'b1100000;
      4'hC: seg_decode = 7'b0110001;
      4'hD: seg_decode = 7'b1000010;
      4'hE: seg_decode = 7'b0110000;
      default: seg_decode = 7'b0111000;
    endcase
  endfunction

  assign slot_end = &slot_cnt;
  assign commit   = slot_end && (idx == LAST_IDX);

  // Scan index k counts from the left; its nibble, DP bit and anode sit at
  // position NUM_DIGITS-1-k of the right-aligned vectors.
  assign sel       = LAST_IDX - idx;
  assign cur_nib   = active_digits[{sel, 2'b00} +: 4];
  assign cur_dp    = active_dp[sel];
  assign duty_slot = slot_cnt[PRESCALE_LOG2-1 -: DUTY_W];

  // A digit is a leading zero when it and everything left of it is zero.
  // The rightmost digit is excluded so a zero value still shows "0".
  always_comb begin
    zero_run  = 1'b1;
    blank_vec = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      zero_run = zero_run && (active_digits[4*(NUM_DIGITS-1-k) +: 4] == 4'h0);
      if (k != NUM_DIGITS - 1) begin
        blank_vec[k] = blank_lz && zero_run;
      end
    end
  end

  assign lit = !blank_vec[idx] && (duty_slot <= brightness);

  always_comb begin
    an_next = '1;
    if (lit) begin
      an_next[sel] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      slot_cnt      <= '0;
      idx           <= '0;
      shadow_digits <= '0;
      shadow_dp     <= '0;
      active_digits <= '0;
      active_dp     <= '0;
      pending       <= 1'b0;
      AN            <= '1;
      CA            <= 7'b1111111;
      DP            <= 1'b1;
      frame_start   <= 1'b0;
    end else begin
      slot_cnt <= slot_cnt + 1'b1;
      if (slot_end) begin
        idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
      end

      if (commit && pending) begin
        active_digits <= shadow_digits;
        active_dp     <= shadow_dp;
      end

      // A load on the commit cycle refills the shadow after its old content
      // has moved to active, so pending must stay set.
      if (load) begin
        shadow_digits <= digits_in;
        shadow_dp     <= dp_in;
        pending       <= 1'b1;
      end else if (commit) begin
        pending <= 1'b0;
      end

      AN          <= an_next;
      CA          <= lit ? seg_decode(cur_nib) : 7'b1111111;
      DP          <= ~(lit && cur_dp);
      frame_start <= (idx == '0) && (slot_cnt == '0);
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// tb/tb_seven_seg_scan_ctrl.sv - scoreboard bench for seven_seg_scan_ctrl

module tb_seven_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] digits_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        pending;
  logic        blank_lz = 1'b0;
  logic [1:0]  brightness = 2'b11;
  logic [3:0]  AN;
  logic [6:0]  CA;
  logic        DP;
  logic        frame_start;

  seven_seg_scan_ctrl #(
    .NUM_DIGITS(4),
    .PRESCALE_LOG2(4),
    .DUTY_W(2)
  ) dut (
    .clk(clk),
    .clr(clr),
    .digits_in(digits_in),
    .dp_in(dp_in),
    .load(load),
    .pending(pending),
    .blank_lz(blank_lz),
    .brightness(brightness),
    .AN(AN),
    .CA(CA),
    .DP(DP),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  int n_assert = 0;
  int n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // kind 0: {AN,CA,DP}; kind 1: pending; kind 2: frame_start
  typedef struct {
    int          cyc;
    string       tag;
    int          kind;
    logic [11:0] val;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0000001;
      4'h1: return 7'b1001111;
      4'h2: return 7'b0010010;
      4'h3: return 7'b0000110;
      4'h4: return 7'b1001100;
      4'h5: return 7'b0100100;
      4'h6: return 7'b0100000;
      4'h7: return 7'b0001111;
      4'h8: return 7'b0000000;
      4'h9: return 7'b0000100;
      4'hA: return 7'b0001000;
      4'hB: return 7'b1100000;
      4'hC: return 7'b0110001;
      4'hD: return 7'b1000010;
      4'hE: return 7'b0110000;
      default: return 7'b0111000;
    endcase
  endfunction

  // Expected pins for the output cycle g cycles after reset release:
  // 16-cycle slots, 4 slots per frame, slot k drives the k-th digit from the left.
  function automatic logic [11:0] model(input int g, input logic [15:0] act,
                                        input logic [3:0] dp, input logic blz,
                                        input logic [1:0] br);
    int          k;
    int          s;
    logic [15:0] upper;
    logic        on;
    logic [3:0]  an;
    k     = (g / 16) % 4;
    s     = g % 16;
    upper = act >> (4 * (3 - k));
    on    = !(blz && (k != 3) && (upper == 16'h0)) && ((s / 4) <= int'(br));
    an    = ~(4'b1000 >> k);
    if (on) return {an, seg_of(upper[3:0]), ~dp[3-k]};
    return {4'hF, 7'h7F, 1'b1};
  endfunction

  task automatic push(input int g, input string tag, input int kind, input logic [11:0] val);
    exp_t e;
    int   i;
    e.cyc  = base + g;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    i = 0;
    while (i < q.size() && q[i].cyc <= e.cyc) i++;
    q.insert(i, e);
  endtask

  task automatic push_out(input int g, input logic [15:0] act, input logic [3:0] dp,
                          input logic blz, input logic [1:0] br);
    push(g, $sformatf("pins_g%0d", g), 0, model(g, act, dp, blz, br));
  endtask

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      mon_e = q.pop_front();
      if (mon_e.cyc < cyc) begin
        n_assert++;
        n_fail++;
        $error("FAIL %s missed observed=none expected=%h", mon_e.tag, mon_e.val);
      end else if (mon_e.kind == 0) begin
        check(mon_e.tag, {AN, CA, DP}, mon_e.val);
      end else if (mon_e.kind == 1) begin
        check(mon_e.tag, {11'b0, pending}, mon_e.val);
      end else begin
        check(mon_e.tag, {11'b0, frame_start}, mon_e.val);
      end
    end
  end

  task automatic wait_g(input int n);
    int guard;
    guard = 0;
    while ((cyc - base) < n && guard < 2000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_an", {8'b0, AN}, 12'h00F);
    check("rst_ca", {5'b0, CA}, 12'h07F);
    check("rst_dp", {11'b0, DP}, 12'h001);
    check("rst_pending", {11'b0, pending}, 12'h000);
    check("rst_frame_start", {11'b0, frame_start}, 12'h000);
    clr  = 1'b0;
    base = cyc + 1;
  endtask

  task automatic pulse_load(input logic [15:0] d, input logic [3:0] p);
    digits_in = d;
    dp_in     = p;
    load      = 1'b1;
    @(negedge clk);
    load      = 1'b0;
  endtask

  initial begin
    int guard;

    // reset and free-running scan of the all-zero display
    do_reset();
    push_out(0,  16'h0, 4'h0, 1'b0, 2'b11);
    push_out(15, 16'h0, 4'h0, 1'b0, 2'b11);
    push_out(16, 16'h0, 4'h0, 1'b0, 2'b11);
    push_out(32, 16'h0, 4'h0, 1'b0, 2'b11);
    push_out(48, 16'h0, 4'h0, 1'b0, 2'b11);
    push(0,  "fs_g0",  2, 12'd1);
    push(1,  "fs_g1",  2, 12'd0);
    push(63, "fs_g63", 2, 12'd0);
    push(64, "fs_g64", 2, 12'd1);
    push(5,  "pend_idle", 1, 12'd0);

    // load 12AF mid-frame: held in shadow until the frame ends
    push(11, "pend_after_load", 1, 12'd1);
    push(62, "pend_before_commit", 1, 12'd1);
    push(63, "pend_after_commit", 1, 12'd0);
    for (int g = 64; g < 128; g += 16) push_out(g, 16'h12AF, 4'b0010, 1'b0, 2'b11);
    wait_g(10);
    pulse_load(16'h12AF, 4'b0010);

    // 0050: first without blanking, then with blanking
    for (int g = 128; g < 192; g += 16) push_out(g, 16'h0050, 4'b1001, 1'b0, 2'b11);
    for (int g = 192; g < 256; g += 16) push_out(g, 16'h0050, 4'b1001, 1'b1, 2'b11);
    push_out(200, 16'h0050, 4'b1001, 1'b1, 2'b11);
    wait_g(70);
    pulse_load(16'h0050, 4'b1001);
    wait_g(180);
    blank_lz = 1'b1;

    // brightness 1 (half on), back to 3, then 0 (quarter on)
    push_out(288, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(295, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(296, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(303, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(304, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(311, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(312, 16'h0050, 4'b1001, 1'b1, 2'b01);
    push_out(319, 16'h0050, 4'b1001, 1'b1, 2'b11);
    push_out(352, 16'h0050, 4'b1001, 1'b1, 2'b00);
    push_out(355, 16'h0050, 4'b1001, 1'b1, 2'b00);
    push_out(356, 16'h0050, 4'b1001, 1'b1, 2'b00);
    push_out(368, 16'h0050, 4'b1001, 1'b1, 2'b00);
    push_out(372, 16'h0050, 4'b1001, 1'b1, 2'b00);
    wait_g(250);
    brightness = 2'b01;
    wait_g(317);
    brightness = 2'b11;

    // second load lands on the commit cycle of the frame that commits the first
    push(342, "pend_first_load", 1, 12'd1);
    push(383, "pend_load_on_commit", 1, 12'd1);
    push(446, "pend_between", 1, 12'd1);
    push(447, "pend_second_commit", 1, 12'd0);
    for (int g = 384; g < 448; g += 16) push_out(g, 16'h789B, 4'b0000, 1'b1, 2'b11);
    push_out(399, 16'h789B, 4'b0000, 1'b1, 2'b11);
    for (int g = 448; g < 512; g += 16) push_out(g, 16'hCDE0, 4'b0000, 1'b1, 2'b11);
    wait_g(340);
    pulse_load(16'h789B, 4'b0000);
    wait_g(344);
    brightness = 2'b00;
    wait_g(377);
    brightness = 2'b11;
    wait_g(382);
    pulse_load(16'hCDE0, 4'b0000);

    // load then reset before commit: load discarded, display all zero
    push(522, "pend_before_clr", 1, 12'd1);
    wait_g(520);
    pulse_load(16'h3460, 4'b1111);
    wait_g(530);
    blank_lz = 1'b0;
    do_reset();
    for (int g = 0; g <= 64; g += 16) push_out(g, 16'h0, 4'h0, 1'b0, 2'b11);
    push(0,  "pend_post_clr", 1, 12'd0);
    push(70, "pend_post_clr_frame", 1, 12'd0);
    push(64, "fs_post_clr", 2, 12'd1);
    wait_g(72);

    guard = 0;
    while (q.size() > 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      n_assert++;
      n_fail++;
      $error("FAIL %s timeout observed=none expected=%h", mon_e.tag, mon_e.val);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
